// File: rtl/maxpool_relu_stream_pkg.sv
// Shared CNN layer parameters used by the convolution and pooling stages.
package maxpool_relu_stream_pkg;

  localparam int unsigned CNN_CONV_W    = 24;
  localparam int unsigned CNN_CONV_H    = 24;
  localparam int unsigned CNN_DATA_BITS = 12;

endpackage

// File: rtl/maxpool_relu_stream_max2_signed.sv
// Combinational two's-complement max of two operands; ties return the shared value.
module max2_signed
  import maxpool_relu_stream_pkg::*;
#(
  parameter int unsigned DATA_BITS = CNN_DATA_BITS
) (
  input  logic [DATA_BITS-1:0] a,
  input  logic [DATA_BITS-1:0] b,
  output logic [DATA_BITS-1:0] max_c
);

  assign max_c = ($signed(a) >= $signed(b)) ? a : b;

endmodule

// File: rtl/maxpool_relu_stream.sv
// Streaming 2x2 stride-2 max-pool followed by ReLU over a raster-order feature map.
module maxpool_relu_stream
  import maxpool_relu_stream_pkg::*;
#(
  parameter int unsigned CONV_W    = CNN_CONV_W,
  parameter int unsigned CONV_H    = CNN_CONV_H,
  parameter int unsigned DATA_BITS = CNN_DATA_BITS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 valid_in,
  input  logic [DATA_BITS-1:0] data_in,
  output logic                 valid_out,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 frame_done
);

  localparam int unsigned COL_W  = $clog2(CONV_W);
  localparam int unsigned ROW_W  = $clog2(CONV_H);
  localparam int unsigned HALF_W = CONV_W / 2;
  localparam int unsigned IDX_W  = COL_W - 1;

  logic [COL_W-1:0]     col;
  logic [ROW_W-1:0]     row;
  logic [DATA_BITS-1:0] pending;
  logic [DATA_BITS-1:0] linebuf [HALF_W];

  logic [IDX_W-1:0]     idx;
  logic [DATA_BITS-1:0] hmax;
  logic [DATA_BITS-1:0] above;
  logic [DATA_BITS-1:0] pmax;
  logic [DATA_BITS-1:0] relu;
  logic                 col_odd;
  logic                 row_odd;
  logic                 col_last;
  logic                 row_last;
  logic                 block_end;

  assign idx       = col[COL_W-1:1];
  assign col_odd   = col[0];
  assign row_odd   = row[0];
  assign col_last  = (col == COL_W'(CONV_W - 1));
  assign row_last  = (row == ROW_W'(CONV_H - 1));
  assign block_end = valid_in && col_odd && row_odd;
  assign above     = linebuf[idx];
  assign relu      = pmax[DATA_BITS-1] ? '0 : pmax;

  max2_signed #(.DATA_BITS(DATA_BITS)) u_hmax (
    .a     (pending),
    .b     (data_in),
    .max_c (hmax)
  );

  max2_signed #(.DATA_BITS(DATA_BITS)) u_pmax (
    .a     (hmax),
    .b     (above),
    .max_c (pmax)
  );

  // Raster position, left-pixel hold and registered pooled output.
  always_ff @(posedge clk) begin
    if (rst) begin
      col        <= '0;
      row        <= '0;
      pending    <= '0;
      valid_out  <= 1'b0;
      frame_done <= 1'b0;
      data_out   <= '0;
    end else begin
      valid_out  <= block_end;
      frame_done <= valid_in && col_last && row_last;
      if (block_end) begin
        data_out <= relu;
      end
      if (valid_in) begin
        if (!col_odd) begin
          pending <= data_in;
        end
        if (col_last) begin
          col <= '0;
          row <= row_last ? '0 : row + ROW_W'(1);
        end else begin
          col <= col + COL_W'(1);
        end
      end
    end
  end

  // Upper-row horizontal maxima; every entry is rewritten before an odd row reads it.
  always_ff @(posedge clk) begin
    if (!rst && valid_in && col_odd && !row_odd) begin
      linebuf[idx] <= hmax;
    end
  end

endmodule

// File: tb/tb_maxpool_relu_stream.sv
// Randomized bench for maxpool_relu_stream against a 2D-image pooling reference model.
module tb_maxpool_relu_stream;
  import maxpool_relu_stream_pkg::*;

  localparam int W = int'(CNN_CONV_W);
  localparam int H = int'(CNN_CONV_H);
  localparam int B = int'(CNN_DATA_BITS);

  logic         clk;
  logic         rst;
  logic         valid_in;
  logic [B-1:0] data_in;
  logic         valid_out;
  logic [B-1:0] data_out;
  logic         frame_done;

  maxpool_relu_stream dut (
    .clk        (clk),
    .rst        (rst),
    .valid_in   (valid_in),
    .data_in    (data_in),
    .valid_out  (valid_out),
    .data_out   (data_out),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int errors;

  // Reference model state: the image seen so far and the raster position of the next pixel.
  int           img [H][W];
  int           mr;
  int           mc;
  logic         exp_valid;
  logic         exp_done;
  logic [B-1:0] exp_data;

  // Per-frame observations.
  int frame_outs;
  int frame_dones;
  int first_out;
  int last_out;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, expv, expv);
    end
  endtask

  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

  task automatic clear_stats();
    frame_outs  = 0;
    frame_dones = 0;
    first_out   = -1;
    last_out    = -1;
  endtask

  // Apply one cycle of input, predict the outputs from the image, then compare after the edge.
  task automatic step(input logic r, input logic v, input logic [B-1:0] d);
    int m;
    rst      = r;
    valid_in = v;
    data_in  = d;
    exp_valid = 1'b0;
    exp_done  = 1'b0;
    if (r) begin
      mr       = 0;
      mc       = 0;
      exp_data = '0;
    end else if (v) begin
      img[mr][mc] = int'($signed(d));
      if ((mr % 2 == 1) && (mc % 2 == 1)) begin
        m = max4(img[mr-1][mc-1], img[mr-1][mc], img[mr][mc-1], img[mr][mc]);
        if (m < 0) m = 0;
        exp_data  = B'(m);
        exp_valid = 1'b1;
        exp_done  = (mr == H - 1) && (mc == W - 1);
      end
      mc++;
      if (mc == W) begin
        mc = 0;
        mr++;
        if (mr == H) mr = 0;
      end
    end
    @(posedge clk);
    #1;
    check("valid_out", 32'(valid_out), 32'(exp_valid));
    check("data_out", 32'(data_out), 32'(exp_data));
    check("frame_done", 32'(frame_done), 32'(exp_done));
    if (valid_out) begin
      frame_outs++;
      if (first_out < 0) first_out = int'(data_out);
      last_out = int'(data_out);
    end
    if (frame_done) frame_dones++;
  endtask

  // Pixel sources: 0 ramp, 1 all -5, 2 single-block pattern, 3 random, 4 ramp with min value at origin.
  function automatic logic [B-1:0] pix(input int kind, input int r, input int c);
    logic [B-1:0] minval;
    minval = '0;
    minval[B-1] = 1'b1;
    case (kind)
      0: return B'(r * W + c);
      1: return B'(-5);
      2: begin
        if (r == 0 && c == 0) return B'(-3);
        if (r == 0 && c == 1) return B'(7);
        if (r == 1 && c == 0) return B'(2);
        if (r == 1 && c == 1) return B'(-100);
        return B'($urandom);
      end
      4: return (r == 0 && c == 0) ? minval : B'(r * W + c);
      default: return B'($urandom);
    endcase
  endfunction

  task automatic run_frame(input int kind, input int idle_pct);
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        while (int'($urandom_range(99)) < idle_pct) step(1'b0, 1'b0, B'($urandom));
        step(1'b0, 1'b1, pix(kind, r, c));
      end
    end
  endtask

  task automatic do_reset(input int cycles);
    for (int i = 0; i < cycles; i++) step(1'b1, 1'($urandom), B'($urandom));
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    rst      = 1'b1;
    valid_in = 1'b0;
    data_in  = '0;
    mr       = 0;
    mc       = 0;
    exp_data = '0;

    do_reset(3);
    check("reset_valid_out", 32'(valid_out), 32'd0);
    check("reset_data_out", 32'(data_out), 32'd0);

    // Continuous ramp frame.
    clear_stats();
    run_frame(0, 0);
    check("ramp_count", 32'(frame_outs), 32'd144);
    check("ramp_first", 32'(first_out), 32'd25);
    check("ramp_last", 32'(last_out), 32'd575);
    check("ramp_done_pulses", 32'(frame_dones), 32'd1);

    // All-negative frame clamps to zero.
    clear_stats();
    run_frame(1, 0);
    check("neg_count", 32'(frame_outs), 32'd144);
    check("neg_first", 32'(first_out), 32'd0);
    check("neg_last", 32'(last_out), 32'd0);

    // Single block pattern after a fresh reset.
    do_reset(1);
    clear_stats();
    run_frame(2, 0);
    check("block_first", 32'(first_out), 32'd7);
    check("block_count", 32'(frame_outs), 32'd144);

    // Ramp with roughly 30% idle cycles.
    clear_stats();
    run_frame(0, 30);
    check("gap_count", 32'(frame_outs), 32'd144);
    check("gap_first", 32'(first_out), 32'd25);
    check("gap_last", 32'(last_out), 32'd575);
    check("gap_done_pulses", 32'(frame_dones), 32'd1);

    // Reset after 300 pixels of a partial frame, then a clean ramp.
    for (int i = 0; i < 300; i++) step(1'b0, 1'b1, B'($urandom));
    do_reset(1);
    clear_stats();
    run_frame(0, 10);
    check("rst_mid_count", 32'(frame_outs), 32'd144);
    check("rst_mid_first", 32'(first_out), 32'd25);
    check("rst_mid_last", 32'(last_out), 32'd575);

    // Back-to-back frames, second starting with the most-negative value.
    clear_stats();
    run_frame(0, 0);
    check("b2b_f1_first", 32'(first_out), 32'd25);
    first_out = -1;
    run_frame(4, 0);
    check("b2b_f2_first", 32'(first_out), 32'd25);
    check("b2b_count", 32'(frame_outs), 32'd288);
    check("b2b_done_pulses", 32'(frame_dones), 32'd2);

    // Random-data frames with gaps.
    for (int f = 0; f < 2; f++) begin
      clear_stats();
      run_frame(3, 20);
      check("rand_count", 32'(frame_outs), 32'd144);
      check("rand_done_pulses", 32'(frame_dones), 32'd1);
    end

    // Idle tail: outputs must stay quiet and hold.
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, B'($urandom));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/maxpool_relu_stream.md
MAXPOOL_RELU_STREAM -- requirements
Module: maxpool_relu_stream

Interface
REQ-001 SHALL have parameter CONV_W, default 24, giving the input feature-map width in pixels (even).
REQ-002 SHALL have parameter CONV_H, default 24, giving the input feature-map height in rows (even).
REQ-003 SHALL have parameter DATA_BITS, default 12, giving the two's-complement pixel width.
REQ-004 SHALL have port clk, input, 1 bit: the only clock; all logic is rising-edge.
REQ-005 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port valid_in, input, 1 bit: data_in carries one convolution pixel this cycle.
REQ-007 SHALL have port data_in, input, DATA_BITS bits: signed pixel, raster order (row-major, left to right).
REQ-008 SHALL have port valid_out, output, 1 bit: data_out holds one pooled pixel this cycle.
REQ-009 SHALL have port data_out, output, DATA_BITS bits: pooled, ReLU'd pixel in raster order of a CONV_W/2 x CONV_H/2 map (the stream the conv2 input window buffer consumes).
REQ-010 SHALL have port frame_done, output, 1 bit: single-cycle pulse coincident with the last pooled pixel of a frame.

Function
REQ-011 SHALL count col (0..CONV_W-1) and row (0..CONV_H-1) only on cycles with valid_in=1; gaps of any length SHALL NOT alter state.
REQ-012 SHALL, on an even col, register data_in as pending left pixel.
REQ-013 SHALL, on an odd col, form hmax = signed max(pending, data_in).
REQ-014 SHALL, on an even row, write hmax into line buffer entry col/2 (CONV_W/2 entries, DATA_BITS each); no output.
REQ-015 SHALL, on an odd row, form pmax = signed max(hmax, linebuf[col/2]) and output max(pmax, 0).
REQ-016 SHALL assert valid_out exactly one cycle after the valid_in cycle carrying the bottom-right pixel of each 2x2 block (latency 1); otherwise valid_out=0.
REQ-017 SHALL hold data_out at its last value when valid_out=0.
REQ-018 SHALL produce exactly (CONV_W/2)*(CONV_H/2) outputs per frame (144 at defaults), CONV_W/2 per odd row.
REQ-019 SHALL wrap col to 0 and increment row after col=CONV_W-1; after row=CONV_H-1, col=CONV_W-1, wrap row to 0 and accept the next frame on the very next valid_in with no idle cycle.
REQ-020 SHALL pulse frame_done with the valid_out of the output at pooled position (CONV_H/2-1, CONV_W/2-1).
REQ-021 SHALL treat the most-negative value (e.g. 12'h800) as a legal input; ReLU clamps it to 0.
REQ-022 SHALL compare signed; equal operands yield that value.
REQ-023 SHALL NOT require a ready/back-pressure signal; the downstream consumer accepts every valid_out.

Reset
REQ-024 SHALL, on rst=1 at a clock edge, set col=0, row=0, valid_out=0, frame_done=0, data_out=0, pending=0.
REQ-025 SHALL NOT require the line buffer to be cleared; its contents are overwritten before use.
REQ-026 SHALL, on reset mid-frame, discard the partial frame; the first valid_in after reset is pixel (0,0).
REQ-027 SHALL ignore valid_in during the reset cycle.

Structure
REQ-028 SHALL take the CONV_W, CONV_H, and DATA_BITS defaults from the shared CNN parameter package used by the convolution layers.
REQ-029 SHALL isolate the signed-max function as the single sub-module max2_signed (combinational, DATA_BITS parameter), instantiated twice.
REQ-030 SHALL be instantiated once per conv1 output channel; it contains no channel logic.

Verification
REQ-031 SHALL cover ramp frame: data_in = row*24+col, continuous valid -> 144 outputs, first = 25, last = 575, frame_done on the 144th.
REQ-032 SHALL cover an all-negative frame (every pixel -5) -> 144 outputs, all 0.
REQ-033 SHALL cover a single block: rows 0-1, cols 0-1 = {-3, 7, 2, -100} -> first output 7, valid_out one cycle after the 4th pixel (row 1, col 1).
REQ-034 SHALL cover random valid_in gaps (30% idle) on a ramp frame -> output sequence identical to REQ-031, no output on idle-derived cycles.
REQ-035 SHALL cover reset after 300 pixels, then a full ramp frame -> exactly 144 outputs matching REQ-031, and no stale output.
REQ-036 SHALL cover two back-to-back frames with 12'h800 at (0,0) of frame 2 -> frame 2 first output = max(0, 1, 24, 25) = 25, two frame_done pulses.
